// File: rtl/boid_update_seq.sv
// Per-frame boid update sequencer: reads each boid, applies accumulators and edge turns, writes back.
// Optional BOID_SPEED_CLAMP_EN saturates each velocity component to +/-MAX_SPEED.
module boid_update_seq #(
    parameter int          NUM_BOIDS     = 2,
    parameter int          LEFT_MARGIN   = 100,
    parameter int          RIGHT_MARGIN  = 540,
    parameter int          TOP_MARGIN    = 100,
    parameter int          BOTTOM_MARGIN = 380,
    parameter logic [31:0] TURN_FACTOR   = 32'h0000_3333,
    parameter logic [31:0] MAX_SPEED     = 32'h0006_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_BOIDS):0]   which_boid,
    output logic [6:0]                   wb_en,
    output logic [31:0]                  x_in_32,
    output logic [31:0]                  y_in_32,
    output logic [31:0]                  vx_in_32,
    output logic [31:0]                  vy_in_32,
    output logic [31:0]                  vx_acc_in,
    output logic [31:0]                  vy_acc_in,
    input  logic [31:0]                  x_out_32,
    input  logic [31:0]                  y_out_32,
    input  logic [31:0]                  vx_out_32,
    input  logic [31:0]                  vy_out_32,
    input  logic [31:0]                  vx_acc_out,
    input  logic [31:0]                  vy_acc_out
);

    localparam int IW = $clog2(NUM_BOIDS) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BOIDS - 1);
    localparam logic signed [31:0] LEFT_S   = LEFT_MARGIN;
    localparam logic signed [31:0] RIGHT_S  = RIGHT_MARGIN;
    localparam logic signed [31:0] TOP_S    = TOP_MARGIN;
    localparam logic signed [31:0] BOTTOM_S = BOTTOM_MARGIN;
    localparam logic signed [31:0] TURN_S   = TURN_FACTOR;
`ifdef BOID_SPEED_CLAMP_EN
    localparam logic signed [31:0] MAX_S    = MAX_SPEED;
`endif

    typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

    state_t            state, state_next;
    logic [IW-1:0]     idx, idx_next;

    logic signed [31:0] x_r, y_r, vx_r, vy_r, vx_acc_r, vy_acc_r;
    logic signed [31:0] x_n, y_n, vx_n, vy_n;
    logic signed [31:0] x_int, y_int;
    logic signed [31:0] vx_calc, vy_calc, x_calc, y_calc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            x_r      <= '0;
            y_r      <= '0;
            vx_r     <= '0;
            vy_r     <= '0;
            vx_acc_r <= '0;
            vy_acc_r <= '0;
            x_n      <= '0;
            y_n      <= '0;
            vx_n     <= '0;
            vy_n     <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (state == READ) begin
                x_r      <= x_out_32;
                y_r      <= y_out_32;
                vx_r     <= vx_out_32;
                vy_r     <= vy_out_32;
                vx_acc_r <= vx_acc_out;
                vy_acc_r <= vy_acc_out;
            end
            if (state == CALC) begin
                x_n  <= x_calc;
                y_n  <= y_calc;
                vx_n <= vx_calc;
                vy_n <= vy_calc;
            end
        end
    end

    // Edge turns compare only the integer pixel part; a position exactly on a margin is left alone.
    always_comb begin
        x_int   = x_r >>> 16;
        y_int   = y_r >>> 16;
        vx_calc = vx_r + vx_acc_r;
        vy_calc = vy_r + vy_acc_r;
        if (x_int < LEFT_S)   vx_calc = vx_calc + TURN_S;
        if (x_int > RIGHT_S)  vx_calc = vx_calc - TURN_S;
        if (y_int < TOP_S)    vy_calc = vy_calc + TURN_S;
        if (y_int > BOTTOM_S) vy_calc = vy_calc - TURN_S;
`ifdef BOID_SPEED_CLAMP_EN
        if (vx_calc > MAX_S)       vx_calc = MAX_S;
        else if (vx_calc < -MAX_S) vx_calc = -MAX_S;
        if (vy_calc > MAX_S)       vy_calc = MAX_S;
        else if (vy_calc < -MAX_S) vy_calc = -MAX_S;
`endif
        x_calc = x_r + vx_calc;
        y_calc = y_r + vy_calc;
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                    idx_next   = '0;
                end
            end
            READ:  state_next = CALC;
            CALC:  state_next = WRITE;
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    state_next = READ;
                    idx_next   = idx + IW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                idx_next   = '0;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy       = (state == READ) || (state == CALC) || (state == WRITE);
        done       = (state == DONE);
        wb_en      = (state == WRITE) ? 7'h7F : 7'h00;
        which_boid = idx;
        x_in_32    = x_n;
        y_in_32    = y_n;
        vx_in_32   = vx_n;
        vy_in_32   = vy_n;
        vx_acc_in  = '0;
        vy_acc_in  = '0;
    end

endmodule
